// File: rtl/gf2_div_pkg.sv
// Shared types, default widths and index-width helper for the GF(2) polynomial divider.
package gf2_div_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam int unsigned DefM = 16;
   localparam int unsigned DefN = 8;

   // Width needed to index a w-bit vector; never less than one bit.
   function automatic int unsigned idx_w(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/gf2_poly_div_if.sv
// Operand/result handshake bundle for gf2_poly_div; master drives operands, slave is the divider.
interface gf2_poly_div_if
   import gf2_div_pkg::*;
#(
   parameter int unsigned M = DefM,
   parameter int unsigned N = DefN
);

   logic         in_valid;
   logic         in_ready;
   logic [M-1:0] dividend;
   logic [N-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [M-1:0] quotient;
   logic [N-2:0] remainder;
   logic         div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/gf2_deg_enc.sv
// Highest-set-bit priority encoder: o_idx is the polynomial degree, o_nonzero flags a nonzero input.
module gf2_deg_enc
   import gf2_div_pkg::*;
#(
   parameter int unsigned W    = 8,
   parameter int unsigned IdxW = idx_w(W)
) (
   input  logic [W-1:0]    i_vec,
   output logic [IdxW-1:0] o_idx,
   output logic            o_nonzero
);

   always_comb begin
      o_idx = '0;
      for (int unsigned j = 0; j < W; j++) begin
         if (i_vec[j]) o_idx = IdxW'(j);
      end
   end

   assign o_nonzero = |i_vec;

endmodule

// File: rtl/gf2_poly_div.sv
// Sequential GF(2) long divider, one quotient bit per cycle behind valid/ready handshakes.
// Optional GF2_DIV_EARLY_TERM_EN starts the walk at deg(dividend) instead of bit M-1.
module gf2_poly_div
   import gf2_div_pkg::*;
#(
   parameter int unsigned M = DefM,
   parameter int unsigned N = DefN
) (
   input  logic          clk,
   input  logic          rst_n,
   gf2_poly_div_if.slave bus
);

   localparam int unsigned IW = idx_w(M);
   localparam int unsigned KW = idx_w(N);

   state_e         r_state, w_state_d;
   logic [M-1:0]   r_a, w_a_d;
   logic [N-2:0]   r_b, w_b_d;
   logic [KW-1:0]  r_k, w_k_d;
   logic [N-2:0]   r_r, w_r_d;
   logic [M-1:0]   r_q, w_q_d;
   logic [IW-1:0]  r_i, w_i_d;
   logic           r_dbz, w_dbz_d;

   logic [KW-1:0]  w_b_deg;
   logic           w_b_nz;
   logic [IW-1:0]  w_start;
   logic           w_a_nz;
   logic [N-1:0]   w_shift;
   logic           w_hit;

   gf2_deg_enc #(.W(N)) u_b_deg (
      .i_vec     (bus.divisor),
      .o_idx     (w_b_deg),
      .o_nonzero (w_b_nz)
   );

`ifdef GF2_DIV_EARLY_TERM_EN
   gf2_deg_enc #(.W(M)) u_a_deg (
      .i_vec     (bus.dividend),
      .o_idx     (w_start),
      .o_nonzero (w_a_nz)
   );
`else
   assign w_start = IW'(M - 1);
   assign w_a_nz  = 1'b1;
`endif

   // The reduction always clears bit k, so the top divisor bit never needs to be stored.
   assign w_shift = {r_r, r_a[r_i]};
   assign w_hit   = w_shift[r_k];

   always_comb begin
      w_state_d = r_state;
      w_a_d     = r_a;
      w_b_d     = r_b;
      w_k_d     = r_k;
      w_r_d     = r_r;
      w_q_d     = r_q;
      w_i_d     = r_i;
      w_dbz_d   = r_dbz;
      unique case (r_state)
         StIdle: begin
            if (bus.in_valid) begin
               w_a_d     = bus.dividend;
               w_b_d     = bus.divisor[N-2:0];
               w_k_d     = w_b_deg;
               w_r_d     = '0;
               w_q_d     = '0;
               w_i_d     = w_start;
               w_dbz_d   = ~w_b_nz;
               w_state_d = (w_b_nz && w_a_nz) ? StRun : StDone;
            end
         end
         StRun: begin
            w_r_d        = w_shift[N-2:0] ^ (r_b & {(N-1){w_hit}});
            w_q_d[r_i]   = w_hit;
            if (r_i == '0) w_state_d = StDone;
            else           w_i_d     = r_i - IW'(1);
         end
         StDone: begin
            if (bus.out_ready) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_a     <= '0;
         r_b     <= '0;
         r_k     <= '0;
         r_r     <= '0;
         r_q     <= '0;
         r_i     <= '0;
         r_dbz   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_a     <= w_a_d;
         r_b     <= w_b_d;
         r_k     <= w_k_d;
         r_r     <= w_r_d;
         r_q     <= w_q_d;
         r_i     <= w_i_d;
         r_dbz   <= w_dbz_d;
      end
   end

   assign bus.in_ready    = (r_state == StIdle);
   assign bus.out_valid   = (r_state == StDone);
   assign bus.quotient    = r_q;
   assign bus.remainder   = r_r;
   assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_gf2_poly_div.sv
// Self-checking bench for gf2_poly_div: directed jobs, backpressure, reset and a random soak
// compared against a shift-and-subtract polynomial division model.
module tb_gf2_poly_div;

   localparam int unsigned M = 16;
   localparam int unsigned N = 8;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [15:0] q;
      logic [6:0]  r;
      logic        dz;
      int          acc;
      int          lat;
      bit          seen;
   } job_t;

   logic clk = 1'b0;
   logic rst_n;
   job_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   rdy_mode = 2;
   bit   prev_acc = 0;
   bit   prev_pop = 0;

   gf2_poly_div_if #(.M(M), .N(N)) bus ();

   gf2_poly_div #(.M(M), .N(N)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #900_000;
      $display("FAIL watchdog actual=timeout required=finish at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   function automatic int deg(input logic [31:0] v);
      int d = -1;
      for (int i = 0; i < 32; i++) if (v[i]) d = i;
      return d;
   endfunction

   function automatic logic [31:0] clmul(input logic [15:0] q, input logic [7:0] b);
      logic [31:0] p = '0;
      for (int i = 0; i < 16; i++) if (q[i]) p ^= (32'(b) << i);
      return p;
   endfunction

   // Textbook long division: cancel the leading term of the running remainder with shifted b.
   task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                          output logic [15:0] q, output logic [6:0] r, output logic dz);
      logic [15:0] rem;
      int db;
      q  = '0;
      r  = '0;
      dz = (b == 8'h00);
      if (!dz) begin
         db  = deg(32'(b));
         rem = a;
         for (int d = 15; d >= db; d--) begin
            if (rem[d]) begin
               rem ^= 16'(16'(b) << (d - db));
               q[d - db] = 1'b1;
            end
         end
         r = rem[6:0];
      end
   endtask

   function automatic int exp_lat(input logic [15:0] a, input logic [7:0] b);
      if (b == 8'h00) return 1;
`ifdef GF2_DIV_EARLY_TERM_EN
      if (a == 16'h0000) return 1;
      return deg(32'(a)) + 2;
`else
      return (a == a) ? M + 1 : M + 1;
`endif
   endfunction

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.out_ready = 1'($urandom_range(0, 1));
            1:       bus.out_ready = 1'b1;
            3:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin : mon
      job_t e;
      bit   acc;
      bit   pop;
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         prev_acc = 0;
         prev_pop = 0;
      end else begin
         pop = 0;
         chk("ready_valid_excl", 32'(bus.in_ready & bus.out_valid), 32'd0);
         if (prev_acc) chk("no_double_accept", 32'(bus.in_ready), 32'd0);
         if (prev_pop) chk("bubble_then_ready", 32'(bus.in_ready), 32'd1);
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'(bus.out_valid), 32'd0);
            end else begin
               e = exp_q[0];
               if (!e.seen) begin
                  exp_q[0].seen = 1;
                  chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                  if (!e.dz) begin
                     chk("clmul_identity",
                         clmul(bus.quotient, e.b) ^ 32'(bus.remainder), 32'(e.a));
                     chk("deg_rem_lt_deg_b",
                         32'(deg(32'(bus.remainder)) < deg(32'(e.b))), 32'd1);
                  end
               end
               chk("quotient", 32'(bus.quotient), 32'(e.q));
               chk("remainder", 32'(bus.remainder), 32'(e.r));
               chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  pop = 1;
               end
            end
         end
         acc = bus.in_valid && bus.in_ready;
         if (acc) begin
            e.a = bus.dividend;
            e.b = bus.divisor;
            ref_div(e.a, e.b, e.q, e.r, e.dz);
            e.acc  = cyc;
            e.lat  = exp_lat(e.a, e.b);
            e.seen = 0;
            exp_q.push_back(e);
         end
         prev_acc = acc;
         prev_pop = pop;
      end
   end

   // Entered just after a rising edge; returns just after the edge that accepts the operands.
   task automatic present_and_wait(input logic [15:0] a, input logic [7:0] b);
      int n = 0;
      bus.dividend = a;
      bus.divisor  = b;
      bus.in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 400);
      if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_job(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                         input logic [6:0] er, input logic ed, input int hold);
      int n = 0;
      rdy_mode = 2;
      present_and_wait(a, b);
      bus.in_valid = 1'b0;
      bus.dividend = 16'($urandom);
      bus.divisor  = 8'($urandom);
      while (!bus.out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("result_valid", 32'(bus.out_valid), 32'd1);
      chk("lit_quotient", 32'(bus.quotient), 32'(eq));
      chk("lit_remainder", 32'(bus.remainder), 32'(er));
      chk("lit_div_by_zero", 32'(bus.div_by_zero), 32'(ed));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
         chk("hold_quotient", 32'(bus.quotient), 32'(eq));
         chk("hold_div_by_zero", 32'(bus.div_by_zero), 32'(ed));
      end
      rdy_mode = 1;
      @(negedge clk);
      rdy_mode = 2;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops(output logic [15:0] a, output logic [7:0] b);
      int sel = int'($urandom_range(0, 15));
      if (sel == 0)      b = 8'h00;
      else if (sel == 1) b = 8'h01;
      else               b = 8'($urandom) & 8'((1 << $urandom_range(1, 8)) - 1);
      sel = int'($urandom_range(0, 15));
      if (sel == 0)      a = 16'h0000;
      else if (sel == 1) a = 16'($urandom) & 16'((1 << $urandom_range(1, 16)) - 1);
      else               a = 16'($urandom);
   endtask

   initial begin
      logic [15:0] mq;
      logic [6:0]  mr;
      logic        mz;
      logic [15:0] ra;
      logic [7:0]  rb;
      int          n;

      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_quotient", 32'(bus.quotient), 32'd0);
      chk("reset_remainder", 32'(bus.remainder), 32'd0);
      chk("reset_div_by_zero", 32'(bus.div_by_zero), 32'd0);

      ref_div(16'h0005, 8'h03, mq, mr, mz);
      chk("model_q_5_3", 32'(mq), 32'h0003);
      chk("model_r_5_3", 32'(mr), 32'h00);
      ref_div(16'h0007, 8'h03, mq, mr, mz);
      chk("model_q_7_3", 32'(mq), 32'h0002);
      chk("model_r_7_3", 32'(mr), 32'h01);
      ref_div(16'h1234, 8'h80, mq, mr, mz);
      chk("model_q_1234_80", 32'(mq), 32'h0024);
      chk("model_r_1234_80", 32'(mr), 32'h34);
      ref_div(16'hBEEF, 8'h00, mq, mr, mz);
      chk("model_dz_beef_0", 32'(mz), 32'd1);

      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_job(16'h0005, 8'h03, 16'h0003, 7'h00, 1'b0, 0);
      do_job(16'h0007, 8'h03, 16'h0002, 7'h01, 1'b0, 0);
      do_job(16'h1234, 8'h80, 16'h0024, 7'h34, 1'b0, 0);
      do_job(16'hFFFF, 8'h01, 16'hFFFF, 7'h00, 1'b0, 2);
      do_job(16'hA5C3, 8'h00, 16'h0000, 7'h00, 1'b1, 10);
`ifdef GF2_DIV_EARLY_TERM_EN
      do_job(16'h0003, 8'h03, 16'h0001, 7'h00, 1'b0, 0);
      do_job(16'h0000, 8'h05, 16'h0000, 7'h00, 1'b0, 0);
`endif

      // Back-to-back with in_valid held high and operands changing while busy.
      rdy_mode = 3;
      for (int j = 0; j < 6; j++) begin
         rand_ops(ra, rb);
         present_and_wait(ra, rb);
      end
      bus.in_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a run.
      rdy_mode = 1;
      present_and_wait(16'hFFFF, 8'h03);
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrun_rst_quotient", 32'(bus.quotient), 32'd0);
      chk("midrun_rst_remainder", 32'(bus.remainder), 32'd0);
      chk("midrun_rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;

      rdy_mode = 0;
      for (int j = 0; j < 1500; j++) begin
         rand_ops(ra, rb);
         present_and_wait(ra, rb);
      end
      bus.in_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("soak_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
